// File: rtl/mem_stage_nb.sv
// mem_stage_nb: MEM pipeline stage for a non-blocking data SRAM.
// Holds one instruction and waits for its data_ok. Buffers the response
// while WB back-pressures, then extracts and extends load data. After a WB
// exception flush it counts and drops responses still owed to cancelled
// instructions.
module mem_stage_nb #(
  parameter int XLEN   = 32,
  parameter int EXC_W  = 82,
  parameter int DROP_W = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             es2ms_valid,
  output logic             ms_allowin,
  input  logic [XLEN-1:0]  es_pc,
  input  logic [EXC_W-1:0] es_exc,
  input  logic [1:0]       es_ld_size,
  input  logic             es_ld_unsigned,
  input  logic             es_res_from_mem,
  input  logic             es_mem_req,
  input  logic             es_req_outstanding,
  input  logic             es_rf_we,
  input  logic [4:0]       es_rf_waddr,
  input  logic             es_csr_re,
  input  logic [XLEN-1:0]  es_alu_result,
  input  logic             data_sram_data_ok,
  input  logic [XLEN-1:0]  data_sram_rdata,
  input  logic             ws_allowin,
  output logic             ms2ws_valid,
  output logic [XLEN-1:0]  ms_pc,
  output logic [EXC_W-1:0] ms_exc,
  output logic             ms_rf_we,
  output logic [4:0]       ms_rf_waddr,
  output logic [XLEN-1:0]  ms_rf_wdata,
  output logic             ms_fwd_we,
  output logic             ms_fwd_csr_re,
  output logic             ms_fwd_pending,
  output logic             ms_ex,
  input  logic             wb_ex
);

  localparam int OFF_W = $clog2(XLEN / 8);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [XLEN-1:0]    rdata_buf_q, rdata_buf_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [EXC_W-1:0]   exc_q, exc_d;
  logic [1:0]         ld_size_q, ld_size_d;
  logic               ld_uns_q, ld_uns_d;
  logic               res_from_mem_q, res_from_mem_d;
  logic               rf_we_q, rf_we_d;
  logic [4:0]         rf_waddr_q, rf_waddr_d;
  logic               csr_re_q, csr_re_d;
  logic [XLEN-1:0]    alu_result_q, alu_result_d;

  logic            ms_valid, in_wait, drop_nz, own_ok, ms_ready_go, accept, handoff;
  logic [XLEN-1:0] load_src, load_shifted, load_ext_data;

  // Load extension: keep the low 8/16/32/64 bits and fill above with the
  // field sign bit, or zeros for unsigned loads. Size 3 is word when XLEN=32.
  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] v,
                                               input logic [1:0]      sz,
                                               input logic            uns);
    logic [XLEN-1:0] r;
    logic            sgn;
    int              w;
    case (sz)
      2'd0: begin w = 8;  sgn = v[7];  end
      2'd1: begin w = 16; sgn = v[15]; end
      2'd2: begin w = 32; sgn = v[31]; end
      default: begin
        if (XLEN == 64) begin w = XLEN; sgn = v[XLEN-1]; end
        else            begin w = 32;   sgn = v[31];     end
      end
    endcase
    for (int i = 0; i < XLEN; i++) begin
      r[i] = (i < w) ? v[i] : (sgn & ~uns);
    end
    return r;
  endfunction

  assign ms_valid    = (state_q != S_EMPTY);
  assign in_wait     = (state_q == S_WAIT);
  assign drop_nz     = (drop_cnt_q != '0);
  assign own_ok      = data_sram_data_ok & ~drop_nz & in_wait;
  assign ms_ready_go = (state_q == S_READY) | own_ok;
  assign handoff     = ms_ready_go & ws_allowin;
  assign ms_allowin  = (state_q == S_EMPTY) | handoff;
  assign accept      = es2ms_valid & ms_allowin & ~wb_ex;

  // Next-state logic; a flush wins over everything, a new accept over handoff.
  always_comb begin
    state_d = state_q;
    if (wb_ex) begin
      state_d = S_EMPTY;
    end else if (accept) begin
      state_d = es_mem_req ? S_WAIT : S_READY;
    end else if (handoff) begin
      state_d = S_EMPTY;
    end else if (own_ok) begin
      state_d = S_READY;
    end
  end

  // Discard counter: on flush, add responses owed to the cancelled entry and
  // to EXE's in-flight request; each dropped data_ok counts one down.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (wb_ex) begin
      drop_cnt_d = drop_cnt_q
                 - DROP_W'(data_sram_data_ok & drop_nz)
                 + DROP_W'(in_wait & ~own_ok)
                 + DROP_W'(es_req_outstanding);
    end else if (data_sram_data_ok & drop_nz) begin
      drop_cnt_d = drop_cnt_q - DROP_W'(1);
    end
  end

  // Payload capture on accept, response capture on own data_ok.
  always_comb begin
    pc_d           = pc_q;
    exc_d          = exc_q;
    ld_size_d      = ld_size_q;
    ld_uns_d       = ld_uns_q;
    res_from_mem_d = res_from_mem_q;
    rf_we_d        = rf_we_q;
    rf_waddr_d     = rf_waddr_q;
    csr_re_d       = csr_re_q;
    alu_result_d   = alu_result_q;
    rdata_buf_d    = rdata_buf_q;
    if (accept) begin
      pc_d           = es_pc;
      exc_d          = es_exc;
      ld_size_d      = es_ld_size;
      ld_uns_d       = es_ld_unsigned;
      res_from_mem_d = es_res_from_mem;
      rf_we_d        = es_rf_we;
      rf_waddr_d     = es_rf_waddr;
      csr_re_d       = es_csr_re;
      alu_result_d   = es_alu_result;
    end
    if (own_ok) begin
      rdata_buf_d = data_sram_rdata;
    end
  end

  // State and payload registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= S_EMPTY;
      drop_cnt_q     <= '0;
      rdata_buf_q    <= '0;
      pc_q           <= '0;
      exc_q          <= '0;
      ld_size_q      <= '0;
      ld_uns_q       <= 1'b0;
      res_from_mem_q <= 1'b0;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= '0;
      csr_re_q       <= 1'b0;
      alu_result_q   <= '0;
    end else begin
      state_q        <= state_d;
      drop_cnt_q     <= drop_cnt_d;
      rdata_buf_q    <= rdata_buf_d;
      pc_q           <= pc_d;
      exc_q          <= exc_d;
      ld_size_q      <= ld_size_d;
      ld_uns_q       <= ld_uns_d;
      res_from_mem_q <= res_from_mem_d;
      rf_we_q        <= rf_we_d;
      rf_waddr_q     <= rf_waddr_d;
      csr_re_q       <= csr_re_d;
      alu_result_q   <= alu_result_d;
    end
  end

  // Load data path: buffered data once READY, bypassed SRAM data otherwise.
  always_comb begin
    load_src      = (state_q == S_READY) ? rdata_buf_q : data_sram_rdata;
    load_shifted  = load_src >> {alu_result_q[OFF_W-1:0], 3'b000};
    load_ext_data = load_ext(load_shifted, ld_size_q, ld_uns_q);
  end

  assign ms2ws_valid    = ms_valid & ms_ready_go;
  assign ms_pc          = pc_q;
  assign ms_exc         = exc_q;
  assign ms_rf_we       = rf_we_q;
  assign ms_rf_waddr    = rf_waddr_q;
  assign ms_rf_wdata    = res_from_mem_q ? load_ext_data : alu_result_q;
  assign ms_fwd_we      = ms_valid & rf_we_q;
  assign ms_fwd_csr_re  = ms_valid & csr_re_q;
  assign ms_fwd_pending = in_wait & ~own_ok;
  assign ms_ex          = ms_valid & (|exc_q);

endmodule

// File: doc/mem_stage_nb.md
# mem_stage_nb

Parameterised memory-access pipeline stage for a non-blocking data SRAM interface, placed between the EXE and WB stages. It holds one instruction and stalls until that instruction's load or store response (`data_ok`) returns. It buffers the returned data while WB back-pressures, then performs XLEN-generic load extraction and sign/zero extension. On a WB exception flush, it counts and silently discards responses that are still in flight for cancelled instructions.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 or 64 are legal.
- `EXC_W`, 82, width of the exception bundle carried with each instruction.
- `DROP_W`, 2, width of the discard counter; it can hold up to 2^DROP_W-1 pending drops.

Ports (clock and reset first):
- `clk` in 1: the single clock; all state updates on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `es2ms_valid` in 1: EXE presents an instruction.
- `ms_allowin` out 1: MEM can accept an instruction.
- `es_pc` in XLEN: instruction PC.
- `es_exc` in EXC_W: exception bundle.
- `es_ld_size` in 2: load size; 0 = byte, 1 = half, 2 = word, 3 = dword.
- `es_ld_unsigned` in 1: 1 selects zero-extension.
- `es_res_from_mem` in 1: the writeback value comes from memory.
- `es_mem_req` in 1: this instruction's SRAM request was accepted (`addr_ok`), so a `data_ok` is owed.
- `es_req_outstanding` in 1: EXE currently holds an accepted request that has not yet been passed to MEM.
- `es_rf_we` in 1, `es_rf_waddr` in 5, `es_csr_re` in 1: register-file writeback control.
- `es_alu_result` in XLEN: ALU result, which is also the memory address.
- `data_sram_data_ok` in 1: response strobe; responses return in request order.
- `data_sram_rdata` in XLEN: response data, valid when `data_ok` is high.
- `ws_allowin` in 1: WB can accept an instruction.
- `ms2ws_valid` out 1: MEM presents an instruction to WB.
- `ms_pc` out XLEN, `ms_exc` out EXC_W: PC and exception bundle forwarded to WB.
- `ms_rf_we` out 1, `ms_rf_waddr` out 5, `ms_rf_wdata` out XLEN: writeback payload.
- `ms_fwd_we` out 1: equals `ms_valid & ms_rf_we`.
- `ms_fwd_csr_re` out 1: equals `ms_valid & csr_re`.
- `ms_fwd_pending` out 1: high while MEM is waiting and `data_ok` is not high this cycle. ID must stall on a match.
- `ms_ex` out 1: equals `ms_valid & |ms_exc`.
- `wb_ex` in 1: WB exception flush.

## Operation
Entry state machine:
- States: EMPTY, WAIT, READY.
- EMPTY -> WAIT on accept with `es_mem_req=1`.
- EMPTY -> READY on accept with `es_mem_req=0`.
- WAIT -> READY on an own `data_ok`; the data is latched into `rdata_buf`.
- READY or WAIT-with-own-`data_ok` -> EMPTY when the instruction is handed to WB and nothing new is accepted.
- On handoff with a simultaneous accept, the next state is WAIT or READY for the new instruction.
- `wb_ex` forces EMPTY from any state, with priority over accept.

Handshake and accept:
- `ms_ready_go` = (state==READY) | (state==WAIT & own_ok).
- `ms_allowin` = (state==EMPTY) | (ms_ready_go & ws_allowin).
- `ms2ws_valid` = `ms_valid & ms_ready_go`.
- Accept = `es2ms_valid & ms_allowin & ~wb_ex`. All payload registers load only on accept.

Discard counter:
- `drop_nz` = (`drop_cnt` != 0).
- `own_ok` = `data_ok & ~drop_nz & state==WAIT`.
- A `data_ok` with `drop_nz` set decrements `drop_cnt` and is otherwise ignored.
- On `wb_ex`, `drop_cnt` becomes: `drop_cnt` - (`data_ok & drop_nz`) + (state==WAIT & ~own_ok) + `es_req_outstanding`.
- Saturation of `drop_cnt` is a protocol error; the bench asserts it never occurs.
- A `data_ok` with `~drop_nz` while not in WAIT is ignored and flagged by a bench assertion.

Load data path:
- Source data: `rdata_buf` in READY, `data_sram_rdata` in the WAIT own_ok cycle (bypass).
- Shift: the source is shifted right by `8*addr[log2(XLEN/8)-1:0]`.
- Extension: take the low 8, 16, 32 or 64 bits by `es_ld_size`. Sign-extend by the top bit of the field, or zero-extend when `ld_unsigned=1`.
- For XLEN=32, size 3 is treated as word.
- `ms_rf_wdata` = extended data if `res_from_mem`, else `alu_result`.

## Timing
- Reset: async; every register clears. Output values in reset:
  - `ms_allowin=1`.
  - `ms2ws_valid=0`, `ms_ex=0`, all `ms_fwd_*=0`.
  - `drop_cnt=0`.
  - `ms_pc`, `ms_exc`, `ms_rf_*` all 0.
- Reset mid-WAIT: the entry and the drop count are lost; the surrounding system resets the SRAM side together with this block.
- Non-memory instruction: accepted at edge N, `ms2ws_valid` high in cycle N+1.
- Load whose `data_ok` arrives in cycle K: `ms2ws_valid` and the correct `ms_rf_wdata` are high in cycle K (combinational bypass).
  - If `ws_allowin=0` in cycle K, the data is held in `rdata_buf` and presented unchanged until handoff.
- Zero-bubble throughput: one instruction per cycle when there is no memory access and `ws_allowin=1`.
- `wb_ex` and `data_ok` in the same cycle: the response goes to the drop counter if `drop_nz`; otherwise it belongs to the MS entry, which is flushed without being counted.

## Test plan
- Reset, then an ALU instruction with `alu_result=0x1234`, `res_from_mem=0`: `ms2ws_valid` is high one cycle after accept and `ms_rf_wdata=0x1234`.
- Loads on `rdata=0x8899AABB` with `data_ok` 3 cycles after accept:
  - ld.b at addr low bits 01 gives 0xFFFFFFAA.
  - ld.hu at addr low bits 10 gives 0x00008899.
  - `ms_fwd_pending` is high for exactly the 3 wait cycles.
- Back-pressure: `data_ok` arrives while `ws_allowin=0` for 4 cycles. Then:
  - the output holds 0x8899AABB;
  - `ms_allowin=0` throughout;
  - a changing `rdata` is ignored;
  - handoff occurs on the first cycle with `ws_allowin=1`.
- Flush with responses outstanding: MS is in WAIT, `es_req_outstanding=1`, and `wb_ex` is pulsed.
  - Required: `drop_cnt=2`.
  - The next two `data_ok` are swallowed.
  - A new load's `data_ok` (the third) is captured correctly.
- Simultaneous `wb_ex` and own `data_ok` with `drop_cnt=0` gives `drop_cnt=0` and `ms_valid=0`. Simultaneous `wb_ex` and `es2ms_valid` leaves nothing accepted.
- XLEN=64: ld.w unsigned at addr low bits 100 on `rdata=0xF0000001_00000000` gives 0x00000000_F0000001. ld.d gives the full word.
